// File: rtl/liteic_master_node_read.sv
// rtl/liteic_master_node_read.sv - per-master AR/R read node of the lite interconnect
// Decodes one AR to a slave slot, requests it over the crossbar and returns the R beat (local DECERR if unmapped).
module liteic_master_node_read #(
  parameter int                            IC_NUM_SLAVE_SLOTS = 4,
  parameter int                            IC_ARADDR_WIDTH    = 32,
  parameter int                            IC_RDATA_WIDTH     = 34,
  parameter int                            SLV_SEL_LSB        = 28,
  parameter int                            SLV_SEL_WIDTH      = 2,
  parameter logic [IC_NUM_SLAVE_SLOTS-1:0] RD_CONNECTIVITY    = '1
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          mst_axil_ar_valid_i,
  output logic                          mst_axil_ar_ready_o,
  input  logic [IC_ARADDR_WIDTH-1:0]    mst_axil_ar_addr_i,
  input  logic [3:0]                    mst_axil_ar_qos_i,
  output logic                          mst_axil_r_valid_o,
  input  logic                          mst_axil_r_ready_i,
  output logic [IC_RDATA_WIDTH-3:0]     mst_axil_r_data_o,
  output logic [1:0]                    mst_axil_r_resp_o,
  output logic [IC_ARADDR_WIDTH-1:0]    cbar_reqst_data_o,
  output logic [3:0]                    cbar_reqst_arqos_o,
  output logic [IC_NUM_SLAVE_SLOTS-1:0] cbar_reqst_val_o,
  input  logic [IC_NUM_SLAVE_SLOTS-1:0] cbar_reqst_rdy_i,
  input  logic [IC_NUM_SLAVE_SLOTS-1:0] cbar_resp_val_i,
  output logic [IC_NUM_SLAVE_SLOTS-1:0] cbar_resp_rdy_o,
  input  logic [IC_RDATA_WIDTH-1:0]     cbar_resp_data_i [IC_NUM_SLAVE_SLOTS],
  output logic                          busy_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_RWAIT = 3'd2,
    ST_ROUT  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  state_e                       state_q, state_d;
  logic [IC_ARADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [3:0]                   qos_q, qos_d;
  logic [SLV_SEL_WIDTH-1:0]     sel_q, sel_d;
  logic [IC_RDATA_WIDTH-1:0]    rbuf_q, rbuf_d;

  logic [SLV_SEL_WIDTH-1:0]     ar_sel;
  logic                         ar_map_ok;
  logic [IC_NUM_SLAVE_SLOTS-1:0] sel_oh;
  logic [IC_RDATA_WIDTH-1:0]    resp_sel_data;

  assign ar_sel = mst_axil_ar_addr_i[SLV_SEL_LSB +: SLV_SEL_WIDTH];

  // Slot decode is loop-based so out-of-range select values simply fail to match any slot.
  always_comb begin
    ar_map_ok     = 1'b0;
    sel_oh        = '0;
    resp_sel_data = '0;
    for (int s = 0; s < IC_NUM_SLAVE_SLOTS; s++) begin
      if (int'(ar_sel) == s && RD_CONNECTIVITY[s]) ar_map_ok = 1'b1;
      if (int'(sel_q) == s) begin
        sel_oh[s]     = 1'b1;
        resp_sel_data = cbar_resp_data_i[s];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      qos_q   <= '0;
      sel_q   <= '0;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      qos_q   <= qos_d;
      sel_q   <= sel_d;
      rbuf_q  <= rbuf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    qos_d   = qos_q;
    sel_d   = sel_q;
    rbuf_d  = rbuf_q;
    case (state_q)
      ST_IDLE: begin
        if (mst_axil_ar_valid_i) begin
          addr_d  = mst_axil_ar_addr_i;
          qos_d   = mst_axil_ar_qos_i;
          sel_d   = ar_sel;
          state_d = ar_map_ok ? ST_REQ : ST_ERR;
        end
      end
      ST_REQ: begin
        if (|(cbar_reqst_rdy_i & sel_oh)) state_d = ST_RWAIT;
      end
      ST_RWAIT: begin
        if (|(cbar_resp_val_i & sel_oh)) begin
          rbuf_d  = resp_sel_data;
          state_d = ST_ROUT;
        end
      end
      ST_ROUT, ST_ERR: begin
        if (mst_axil_r_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All master-facing R outputs decode only registered state, never the crossbar inputs.
  always_comb begin
    mst_axil_ar_ready_o = (state_q == ST_IDLE) && rstn_i;
    cbar_reqst_data_o   = addr_q;
    cbar_reqst_arqos_o  = qos_q;
    cbar_reqst_val_o    = (state_q == ST_REQ) ? sel_oh : '0;
    cbar_resp_rdy_o     = (state_q == ST_RWAIT) ? sel_oh : '0;
    mst_axil_r_valid_o  = (state_q == ST_ROUT) || (state_q == ST_ERR);
    mst_axil_r_data_o   = '0;
    mst_axil_r_resp_o   = 2'b00;
    if (state_q == ST_ROUT) begin
      mst_axil_r_data_o = rbuf_q[IC_RDATA_WIDTH-1:2];
      mst_axil_r_resp_o = rbuf_q[1:0];
    end else if (state_q == ST_ERR) begin
      mst_axil_r_resp_o = 2'b11;
    end
    busy_o = (state_q != ST_IDLE);
  end

endmodule
